// File: rtl/bp_softcore_sram_mem.sv
// SRAM-backed memory endpoint for the softcore mem_cmd/mem_resp channel (no-DRAM builds).
// Optional address range check: define BP_SOFTCORE_MEM_RANGE_CHECK_EN.
package bp_softcore_sram_mem_pkg;
  localparam int paddr_width_p     = 40;
  localparam int cce_block_width_p = 512;
  localparam int payload_width_p   = 16;

  localparam logic [3:0] e_cce_mem_rd    = 4'd0;
  localparam logic [3:0] e_cce_mem_wr    = 4'd1;
  localparam logic [3:0] e_cce_mem_uc_rd = 4'd2;
  localparam logic [3:0] e_cce_mem_uc_wr = 4'd3;

  typedef struct packed {
    logic [3:0]                   msg_type;
    logic [paddr_width_p-1:0]     addr;
    logic [2:0]                   size;
    logic [payload_width_p-1:0]   payload;
    logic [cce_block_width_p-1:0] data;
  } bp_cce_mem_msg_s;

  localparam int cce_mem_msg_width_lp = $bits(bp_cce_mem_msg_s);
endpackage

module bp_softcore_sram_mem
  import bp_softcore_sram_mem_pkg::*;
#(
  parameter int                       mem_els_p  = 1024,
  parameter logic [paddr_width_p-1:0] mem_base_p = 'h8000_0000
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [cce_mem_msg_width_lp-1:0] mem_cmd_i,
  input  logic                            mem_cmd_v_i,
  output logic                            mem_cmd_ready_o,
  output logic [cce_mem_msg_width_lp-1:0] mem_resp_o,
  output logic                            mem_resp_v_o,
  input  logic                            mem_resp_yumi_i,
  output logic                            error_o
);
  localparam int lg_els_lp = $clog2(mem_els_p);
  localparam int bytes_lp  = cce_block_width_p / 8;
  localparam logic [paddr_width_p:0] limit_lp =
    {1'b0, mem_base_p} + (paddr_width_p+1)'(mem_els_p * bytes_lp);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_RESP} state_e;
  state_e r_state, w_state_n;
  logic [lg_els_lp-1:0] r_cnt;

  // 2-entry command FIFO; contents need no reset, occupancy gates them
  bp_cce_mem_msg_s r_fifo [2];
  logic            r_wp, r_rp;
  logic [1:0]      r_fcnt;
  logic            w_enq, w_deq;
  bp_cce_mem_msg_s w_head;

  assign w_head          = r_fifo[r_rp];
  assign mem_cmd_ready_o = (r_fcnt != 2'd2) && (r_state != S_CLEAR);
  assign w_enq           = mem_cmd_v_i && mem_cmd_ready_o;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_wp <= 1'b0; r_rp <= 1'b0; r_fcnt <= 2'd0;
    end else if (r_state == S_CLEAR) begin
      r_wp <= 1'b0; r_rp <= 1'b0; r_fcnt <= 2'd0;
    end else begin
      if (w_enq) r_wp <= ~r_wp;
      if (w_deq) r_rp <= ~r_rp;
      r_fcnt <= r_fcnt + 2'(w_enq) - 2'(w_deq);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_enq) r_fifo[r_wp] <= mem_cmd_i;
  end

  // Head decode; size code 7 is undefined and treated as a full block
  logic [2:0]           w_size;
  logic [6:0]           w_nbytes;
  logic [5:0]           w_off;
  logic [lg_els_lp-1:0] w_row;
  logic                 w_is_rd, w_is_wr, w_oor;
  logic [bytes_lp-1:0]  w_bmask;
  logic [cce_block_width_p-1:0] w_wdata_sh;

  assign w_size     = (w_head.size == 3'd7) ? 3'd6 : w_head.size;
  assign w_nbytes   = 7'd1 << w_size;
  assign w_off      = w_head.addr[5:0] & ~6'(w_nbytes - 7'd1);
  assign w_row      = lg_els_lp'((w_head.addr - mem_base_p) >> 6);
  assign w_is_rd    = (w_head.msg_type == e_cce_mem_rd) || (w_head.msg_type == e_cce_mem_uc_rd);
  assign w_is_wr    = (w_head.msg_type == e_cce_mem_wr) || (w_head.msg_type == e_cce_mem_uc_wr);
  assign w_bmask    = (~({bytes_lp{1'b1}} << w_nbytes)) << w_off;
  assign w_wdata_sh = w_head.data << {w_off, 3'b000};

`ifdef BP_SOFTCORE_MEM_RANGE_CHECK_EN
  assign w_oor = (w_head.addr < mem_base_p) || ({1'b0, w_head.addr} >= limit_lp);
`else
  assign w_oor = 1'b0;
`endif

  // SRAM port, shared by the clear sweep and command service
  logic                         w_we, w_re;
  logic [lg_els_lp-1:0]         w_addr;
  logic [cce_block_width_p-1:0] w_wdata;
  logic [bytes_lp-1:0]          w_wmask;
  logic [cce_block_width_p-1:0] r_mem [mem_els_p];
  logic [cce_block_width_p-1:0] r_rdata;

  always_ff @(posedge clk_i) begin
    if (w_re) r_rdata <= r_mem[w_addr];
    if (w_we) begin
      for (int b = 0; b < bytes_lp; b++) begin
        if (w_wmask[b]) r_mem[w_addr][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_deq     = 1'b0;
    w_re      = 1'b0;
    w_we      = 1'b0;
    w_addr    = w_row;
    w_wdata   = w_wdata_sh;
    w_wmask   = w_bmask;
    case (r_state)
      S_CLEAR: begin
        w_we    = 1'b1;
        w_addr  = r_cnt;
        w_wdata = '0;
        w_wmask = '1;
        if (&r_cnt) w_state_n = S_IDLE;
      end
      S_IDLE: begin
        if (r_fcnt != 2'd0) begin
          w_deq     = 1'b1;
          w_re      = w_is_rd && !w_oor;
          w_we      = w_is_wr && !w_oor;
          w_state_n = S_RESP;
        end
      end
      S_RESP: if (mem_resp_yumi_i) w_state_n = S_IDLE;
      default: w_state_n = S_CLEAR;
    endcase
  end

  // Response header captured at dequeue and held through RESP
  logic [3:0]                 r_type;
  logic [paddr_width_p-1:0]   r_addr;
  logic [2:0]                 r_size;
  logic [payload_width_p-1:0] r_payload;
  logic [6:0]                 r_nbytes;
  logic [5:0]                 r_off;
  logic                       r_rd;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= S_CLEAR; r_cnt <= '0;
      r_type <= '0; r_addr <= '0; r_size <= '0; r_payload <= '0;
      r_nbytes <= '0; r_off <= '0; r_rd <= 1'b0;
    end else begin
      r_state <= w_state_n;
      if (r_state == S_CLEAR) r_cnt <= r_cnt + 1'b1;
      if (w_deq) begin
        r_type    <= w_head.msg_type;
        r_addr    <= w_head.addr;
        r_size    <= w_head.size;
        r_payload <= w_head.payload;
        r_nbytes  <= w_nbytes;
        r_off     <= w_off;
        r_rd      <= w_is_rd && !w_oor;
      end
    end
  end

`ifdef BP_SOFTCORE_MEM_RANGE_CHECK_EN
  logic r_err;
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)               r_err <= 1'b0;
    else if (w_deq && w_oor)   r_err <= 1'b1;
  end
  assign error_o = r_err;
`else
  assign error_o = 1'b0;
`endif

  logic [cce_block_width_p-1:0] w_rshift, w_rmask;
  bp_cce_mem_msg_s              w_resp;

  assign w_rshift = r_rdata >> {r_off, 3'b000};
  assign w_rmask  = ~({cce_block_width_p{1'b1}} << {r_nbytes, 3'b000});

  always_comb begin
    w_resp          = '0;
    w_resp.msg_type = r_type;
    w_resp.addr     = r_addr;
    w_resp.size     = r_size;
    w_resp.payload  = r_payload;
    w_resp.data     = r_rd ? (w_rshift & w_rmask) : '0;
  end

  assign mem_resp_v_o = (r_state == S_RESP);
  assign mem_resp_o   = (r_state == S_RESP) ? w_resp : '0;
endmodule

// File: tb/tb_bp_softcore_sram_mem.sv
// Randomized bench for bp_softcore_sram_mem against a byte-array memory model.
// Set BP_SOFTCORE_MEM_RANGE_CHECK_EN consistently with the RTL build.
module tb_bp_softcore_sram_mem;
  import bp_softcore_sram_mem_pkg::*;

  localparam int          ELS  = 16;
  localparam logic [39:0] BASE = 40'h00_8000_0000;
  localparam int          W    = cce_mem_msg_width_lp;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] cmd, resp;
  logic         cmd_v, cmd_rdy, resp_v, yumi, err;

  bp_softcore_sram_mem #(.mem_els_p(ELS), .mem_base_p(BASE)) dut (
    .clk_i(clk), .reset_i(rst),
    .mem_cmd_i(cmd), .mem_cmd_v_i(cmd_v), .mem_cmd_ready_o(cmd_rdy),
    .mem_resp_o(resp), .mem_resp_v_o(resp_v), .mem_resp_yumi_i(yumi),
    .error_o(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [7:0]      mem_m [ELS*64];
  bit              err_m;
  bp_cce_mem_msg_s cmdq[$];
  bp_cce_mem_msg_s expq[$];
  int              accq[$];
  logic [511:0]    rdq[$];
  int              last_ret;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Whole-memory-as-bytes view: apply the command in order, return the response it must produce
  function automatic bp_cce_mem_msg_s model(input bp_cce_mem_msg_s c);
    bp_cce_mem_msg_s r;
    int n, off, row;
    logic [39:0] rel;
    bit oor, rd, wr;
    r = c;
    r.data = '0;
    n   = 1 << ((c.size > 3'd6) ? 6 : int'(c.size));
    off = (int'(c.addr[5:0]) / n) * n;
    rel = c.addr - BASE;
    row = int'(rel[39:6] % ELS);
    oor = 1'b0;
`ifdef BP_SOFTCORE_MEM_RANGE_CHECK_EN
    oor = (c.addr < BASE) || (c.addr >= BASE + 40'(ELS*64));
`endif
    if (oor) err_m = 1'b1;
    rd = (c.msg_type == e_cce_mem_rd) || (c.msg_type == e_cce_mem_uc_rd);
    wr = (c.msg_type == e_cce_mem_wr) || (c.msg_type == e_cce_mem_uc_wr);
    for (int i = 0; i < n; i++) begin
      if (wr && !oor) mem_m[row*64 + off + i] = c.data[8*i +: 8];
      if (rd && !oor) r.data[8*i +: 8] = mem_m[row*64 + off + i];
    end
    return r;
  endfunction

  function automatic bp_cce_mem_msg_s mk(input logic [3:0] t, input logic [39:0] a,
                                         input logic [2:0] s, input logic [511:0] d);
    bp_cce_mem_msg_s m;
    m.msg_type = t;
    m.addr     = a;
    m.size     = s;
    m.payload  = 16'($urandom);
    m.data     = d;
    return m;
  endfunction

  function automatic logic [511:0] rnd_data();
    logic [511:0] d;
    for (int k = 0; k < 16; k++) d[32*k +: 32] = $urandom;
    return d;
  endfunction

  task automatic do_reset();
    rst = 1'b1; cmd_v = 1'b0; yumi = 1'b0; cmd = '0;
    #1;
    chk("rst_resp_v", W'(resp_v), W'(0));
    chk("rst_ready", W'(cmd_rdy), W'(0));
    chk("rst_error", W'(err), W'(0));
    chk("rst_resp", resp, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    foreach (mem_m[i]) mem_m[i] = 8'h00;
    err_m = 1'b0;
    cmdq.delete(); expq.delete(); accq.delete();
    last_ret = -100;
    #1;
    for (int i = 0; i < ELS; i++) begin
      if (i > 0) @(negedge clk);
      chk("clear_ready", W'(cmd_rdy), W'(0));
      chk("clear_resp_v", W'(resp_v), W'(0));
    end
    @(negedge clk);
    chk("ready_after_clear", W'(cmd_rdy), W'(1));
  endtask

  // Offer queued commands every cycle; each response is held 'hold' cycles before yumi
  task automatic run_stream(input int hold, input int budget);
    int t = 0, held = 0, ef;
    bit seen = 1'b0;
    rdq.delete();
    while ((cmdq.size() > 0 || expq.size() > 0) && t < budget) begin
      @(negedge clk);
      t++;
      cmd_v = (cmdq.size() > 0);
      cmd   = cmd_v ? cmdq[0] : '0;
      yumi  = 1'b0;
      chk("ready", W'(cmd_rdy), W'((expq.size() - int'(resp_v)) < 2));
      if (resp_v) begin
        if (expq.size() == 0) chk("spurious_resp", W'(1), W'(0));
        else begin
          chk("resp", resp, expq[0]);
          if (!seen) begin
            seen = 1'b1;
            ef = ((accq[0] > last_ret) ? accq[0] : last_ret) + 2;
            chk("latency", W'(cyc), W'(ef));
          end
          if (held >= hold) yumi = 1'b1;
          else held++;
        end
      end
      if (cmd_v && cmd_rdy) begin
        accq.push_back(cyc);
        expq.push_back(model(cmdq.pop_front()));
      end
      if (yumi) begin
        bp_cce_mem_msg_s r;
        r = resp;
        rdq.push_back(r.data);
        last_ret = cyc;
        void'(expq.pop_front());
        void'(accq.pop_front());
        seen = 1'b0;
        held = 0;
      end
    end
    @(posedge clk);
    #1;
    cmd_v = 1'b0; yumi = 1'b0; cmd = '0;
    chk("drained", W'(cmdq.size() + expq.size()), W'(0));
    chk("error_o", W'(err), W'(err_m));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bp_cce_mem_msg_s c;
    int nb;
    rst = 1'b1; cmd_v = 1'b0; yumi = 1'b0; cmd = '0;
    last_ret = -100;

    // reset / clear sweep, first read of a cleared row
    do_reset();
    cmdq.push_back(mk(e_cce_mem_uc_rd, BASE, 3'd3, rnd_data()));
    run_stream(0, 50);
    if (rdq.size() > 0) chk("t1_rd_zero", W'(rdq[0]), W'(0));

    // write then read back, full and sub-word
    cmdq.push_back(mk(e_cce_mem_uc_wr, BASE + 40'h8, 3'd3, 512'h1122334455667788));
    cmdq.push_back(mk(e_cce_mem_uc_rd, BASE + 40'h8, 3'd3, '0));
    cmdq.push_back(mk(e_cce_mem_uc_rd, BASE + 40'h9, 3'd0, '0));
    run_stream(0, 50);
    if (rdq.size() == 3) begin
      chk("t2_wr_data", W'(rdq[0]), W'(0));
      chk("t2_rd64", W'(rdq[1]), W'(64'h1122334455667788));
      chk("t2_rd8", W'(rdq[2]), W'(8'h77));
    end else chk("t2_count", W'(rdq.size()), W'(3));

    // back-to-back: three commands offered every cycle, yumi immediate
    cmdq.push_back(mk(e_cce_mem_wr, BASE + 40'h100, 3'd6, rnd_data()));
    cmdq.push_back(mk(e_cce_mem_rd, BASE + 40'h100, 3'd6, '0));
    cmdq.push_back(mk(e_cce_mem_uc_rd, BASE + 40'h104, 3'd2, '0));
    run_stream(0, 50);

    // backpressure: every response held 10 cycles
    cmdq.push_back(mk(e_cce_mem_uc_wr, BASE + 40'h3F, 3'd0, rnd_data()));
    cmdq.push_back(mk(e_cce_mem_uc_rd, BASE + 40'h38, 3'd3, '0));
    run_stream(10, 100);

    // wrap-around / range check
    cmdq.push_back(mk(e_cce_mem_uc_wr, BASE + 40'h400, 3'd2, 512'hDEADBEEF));
    cmdq.push_back(mk(e_cce_mem_uc_rd, BASE, 3'd2, '0));
    run_stream(0, 50);
`ifdef BP_SOFTCORE_MEM_RANGE_CHECK_EN
    if (rdq.size() == 2) chk("t5_rd", W'(rdq[1]), W'(0));
    chk("t5_err", W'(err), W'(1));
`else
    if (rdq.size() == 2) chk("t5_rd", W'(rdq[1]), W'(32'hDEADBEEF));
    chk("t5_err", W'(err), W'(0));
`endif

    // reset while in RESP with one command pending
    @(negedge clk);
    cmd_v = 1'b1;
    cmd   = mk(e_cce_mem_uc_wr, BASE + 40'h40, 3'd3, 512'hA5A5_5A5A_0F0F_F0F0);
    @(negedge clk);
    cmd   = mk(e_cce_mem_uc_rd, BASE + 40'h40, 3'd3, '0);
    @(negedge clk);
    cmd_v = 1'b0;
    chk("t6_in_resp", W'(resp_v), W'(1));
    do_reset();
    cmdq.push_back(mk(e_cce_mem_uc_rd, BASE + 40'h40, 3'd3, '0));
    run_stream(0, 50);
    if (rdq.size() == 1) chk("t6_rezeroed", W'(rdq[0]), W'(0));
    else chk("t6_count", W'(rdq.size()), W'(1));

    // randomized traffic across two memory spans (wrap / out-of-range)
    for (int b = 0; b < 12; b++) begin
      nb = $urandom_range(1, 6);
      for (int k = 0; k < nb; k++) begin
        c = mk(4'($urandom_range(0, 4)), BASE + 40'($urandom_range(0, 2*ELS*64 - 1)),
               3'($urandom_range(0, 6)), rnd_data());
        cmdq.push_back(c);
      end
      run_stream($urandom_range(0, 3), 200);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
